panel_switch_scanner: RTL and testbench
=======================================

# panel_switch_scanner

Front-panel switch-matrix scanner for the Altair build: drives switch-matrix rows, samples the column returns, and produces debounced address/data switch levels plus single-cycle control-switch press pulses for the machine core. It is the input-direction counterpart of the time-multiplexed front-panel LED display. It runs entirely in the `clk` domain, beside the LED scan logic in the top level.

## Interface
- `SCAN_DIV`, default 4096: clocks per row slot; legal range ≥ 4.
- `DEBOUNCE`, default 8: identical consecutive samples of a row required before its debounced value updates; legal range 2..15.

Ports:
- `clk`  in  1: system clock, single domain.
- `resetn`  in  1: reset, synchronous, active-low.
- `sw_col`  in  8: column returns; active-low, open when high (external pull-ups); asynchronous.
- `sw_row`  out  3: row drive; active-low one-hot; row0 = A7..A0, row1 = A15..A8, row2 = control.
- `sw_addr`  out  16: debounced address/data switch levels; 1 = switch closed.
- `ctl_level`  out  8: debounced control switch levels; bit0 RUN, 1 STOP, 2 STEP, 3 EXAMINE, 4 EXAMINE_NEXT, 5 DEPOSIT, 6 DEPOSIT_NEXT, 7 RESET.
- `ctl_pulse`  out  8: one-`clk` pulse per debounced 0→1 transition of the matching `ctl_level` bit.
- `frame`  out  1: one-`clk` pulse after the row2 sample completes.

## Operation
- Synchronizer: `sw_col` passes through 2 flops, then is inverted so that 1 = closed (`col_s`).
- Slot counter `div`, 0..SCAN_DIV-1, free-running. A row index `r` cycles 0→1→2→0. `r` advances and `sw_row` changes on the cycle `div` wraps to 0.
- Sample point: the cycle where `div == SCAN_DIV-1`. `raw = col_s` for row `r`. The sync latency plus settling must fit within the slot; SCAN_DIV ≥ 4 guarantees this.
- Per-row state: `prev[r]` (8 b), `cnt[r]` (4 b, saturating), `deb[r]` (8 b). Each sample is processed as follows:
  - If `raw != prev[r]`: `prev[r] <= raw`, `cnt[r] <= 1`. `deb[r]` is unchanged.
  - Otherwise: `cnt[r] <= min(cnt[r]+1, DEBOUNCE)`. If the new count equals DEBOUNCE, `deb[r] <= raw`. In saturation the rewrite is idempotent.
- A change on any bit restarts the whole row's counter. All bits of a row update together. There is no ghosting or anti-diode correction; the matrix has diodes.
- Outputs: `sw_addr = {deb[1], deb[0]}`, `ctl_level = deb[2]`. Both are registered state, never combinational from `sw_col`.
- `ctl_pulse[i]` is registered. It is 1 for exactly the cycle after `deb[2][i]` goes 0→1. Releases (1→0) produce no pulse. Several bits rising in one update pulse together.
- `frame` is 1 on the cycle after the row2 sample.

## Timing
- Reset (`resetn` low at a `clk` edge) gives the following, all taking effect on the next cycle:
  - `div=0`, `r=0`, `sw_row=3'b110`.
  - `prev`, `cnt` and `deb` all 0.
  - `sw_addr=0`, `ctl_level=0`, `ctl_pulse=0`, `frame=0`.
  - Synchronizer flops are cleared to the "open" value.
- Reset mid-scan aborts the slot. No pulse is emitted for state cleared by reset.
- Row period is SCAN_DIV clocks and frame period is 3·SCAN_DIV clocks. With the 12 MHz HFOSC and defaults: 341 µs per row, ~1.02 ms per frame.
- Press latency: a switch stable before a row's slot starts appears on `deb` at the DEBOUNCE-th consecutive identical sample of that row. That is (DEBOUNCE-1) frames after the first sample, at the sample cycle. `ctl_pulse` follows 1 clock later.
- A change shorter than one sample interval may be missed entirely; this is the intended filtering.
- The `cnt` saturation boundary is at DEBOUNCE; the counter never wraps.
- `div` wrap and row advance coincide. Sampling never coincides with a row change.

## Test plan
Bench settings: SCAN_DIV=8, DEBOUNCE=3, models a diode switch matrix.

- Reset release with all switches open → `sw_row` sequences 110→101→011→110, changing every 8 clocks. `frame` pulses every 24 clocks. All outputs stay 0.
- Close A0 and A15 from before the first slot → `sw_addr=16'h8001` exactly at the 3rd row0 and 3rd row1 sample respectively. Unchanged before that.
- Close DEPOSIT (ctl bit 5) → `ctl_level=8'h20` at the 3rd row2 sample. `ctl_pulse=8'h20` for exactly one clock, 1 cycle later. Holding the switch for 10 frames produces no further pulse.
- Bounce on EXAMINE: closed, open, closed, closed, closed on successive row2 samples → update only at the 5th sample, single pulse. Then release → `ctl_level` bit clears after 3 open samples, no pulse.
- Toggle A7 every frame → `sw_addr[7]` never changes. Meanwhile A8, held stable, updates normally, showing per-row independence.
- Assert `resetn` low for 1 clock after `ctl_level=8'h01` is established → all outputs 0 and `sw_row=110` the next cycle. No `ctl_pulse` until 3 fresh row2 samples with RUN held.

Source files
------------

// File: rtl/panel_switch_scanner.sv
// panel_switch_scanner
// ---------------------------------------------------------------------------
// Front-panel switch-matrix scanner. Drives one matrix row at a time
// (active-low), samples the column returns once per row slot and debounces
// each row as a whole. The results are:
//   - debounced address/data switch levels,
//   - debounced control switch levels,
//   - a one-clock press pulse per control switch.
// Everything runs in the single clk domain.
//
// Ports
//   clk        in   1   system clock
//   resetn     in   1   synchronous, active-low reset
//   sw_col     in   8   column returns, active-low (open = 1), asynchronous
//   sw_row     out  3   row drive, active-low one-hot:
//                         row0 = A7..A0, row1 = A15..A8, row2 = control
//   sw_addr    out 16   debounced address/data levels, 1 = closed
//   ctl_level  out  8   debounced control levels:
//                         RUN, STOP, STEP, EXAMINE, EXAMINE_NEXT,
//                         DEPOSIT, DEPOSIT_NEXT, RESET (bit0..bit7)
//   ctl_pulse  out  8   one-clock pulse on each debounced 0->1 of ctl_level
//   frame      out  1   one-clock pulse on the cycle after the row2 sample
//
// The row sequencer state is directly observable on sw_row, which is a
// registered one-hot decode of the state register.
// ---------------------------------------------------------------------------
module panel_switch_scanner #(
   parameter int SCAN_DIV = 4096,  // clocks per row slot, >= 4
   parameter int DEBOUNCE = 8      // identical samples before update, 2..15
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  sw_col,
   output logic [2:0]  sw_row,
   output logic [15:0] sw_addr,
   output logic [7:0]  ctl_level,
   output logic [7:0]  ctl_pulse,
   output logic        frame
);

   localparam int               DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE);

   typedef enum logic [1:0] {
      ROW_ALO = 2'd0,  // A7..A0
      ROW_AHI = 2'd1,  // A15..A8
      ROW_CTL = 2'd2   // control switches
   } row_e;

   // ------------------------------------------------------------------
   // Row sequencer
   // ------------------------------------------------------------------
   row_e             row_q, row_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       sw_row_q, sw_row_d;
   logic             sample;
   logic [1:0]       row_idx;

   // The last clock of a slot is the sample point. The row changes on the
   // same edge that consumes the sample, so a sample never sees a row
   // that is still settling.
   assign sample  = (div_q == DIV_LAST);
   assign row_idx = row_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         row_q    <= ROW_ALO;
         div_q    <= '0;
         sw_row_q <= 3'b110;
      end else begin
         row_q    <= row_d;
         div_q    <= div_d;
         sw_row_q <= sw_row_d;
      end
   end

   always_comb begin
      row_d = row_q;
      div_d = div_q + DIV_W'(1);
      if (sample) begin
         div_d = '0;
         case (row_q)
            ROW_ALO: row_d = ROW_AHI;
            ROW_AHI: row_d = ROW_CTL;
            default: row_d = ROW_ALO;
         endcase
      end
      case (row_d)
         ROW_ALO: sw_row_d = 3'b110;
         ROW_AHI: sw_row_d = 3'b101;
         ROW_CTL: sw_row_d = 3'b011;
         default: sw_row_d = 3'b110;
      endcase
   end

   // ------------------------------------------------------------------
   // Column synchronizer (reset to the "all open" level)
   // ------------------------------------------------------------------
   logic [7:0] sync1_q, sync2_q;
   logic [7:0] col_s;

   assign col_s = ~sync2_q;  // 1 = switch closed

   // ------------------------------------------------------------------
   // Per-row debounce
   // A change on any bit restarts the whole row's run count. The row's
   // debounced value is rewritten whenever the run reaches DEBOUNCE; once
   // saturated the rewrite stores the same value again.
   // ------------------------------------------------------------------
   logic [7:0] prev_q [3];
   logic [3:0] cnt_q  [3];
   logic [7:0] deb_q  [3];

   logic [7:0] prev_sel, deb_sel, prev_new, deb_new;
   logic [3:0] cnt_sel, cnt_new;

   always_comb begin
      prev_sel = prev_q[row_idx];
      cnt_sel  = cnt_q[row_idx];
      deb_sel  = deb_q[row_idx];
      prev_new = prev_sel;
      cnt_new  = cnt_sel;
      deb_new  = deb_sel;
      if (col_s != prev_sel) begin
         prev_new = col_s;
         cnt_new  = 4'd1;
      end else begin
         cnt_new = (cnt_sel >= DEB_N) ? DEB_N : cnt_sel + 4'd1;
         if (cnt_new == DEB_N) begin
            deb_new = col_s;
         end
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   logic [7:0] ctl_last_q;   // ctl_level one clock ago, for edge detect
   logic [7:0] ctl_pulse_q;
   logic       frame_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1_q     <= 8'hFF;
         sync2_q     <= 8'hFF;
         for (int i = 0; i < 3; i++) begin
            prev_q[i] <= '0;
            cnt_q[i]  <= '0;
            deb_q[i]  <= '0;
         end
         ctl_last_q  <= '0;
         ctl_pulse_q <= '0;
         frame_q     <= 1'b0;
      end else begin
         sync1_q <= sw_col;
         sync2_q <= sync1_q;
         if (sample) begin
            prev_q[row_idx] <= prev_new;
            cnt_q[row_idx]  <= cnt_new;
            deb_q[row_idx]  <= deb_new;
         end
         frame_q <= sample && (row_q == ROW_CTL);
         // Rising-edge detect on the registered control levels: the pulse
         // lands one clock after the level changes. Reset clears both the
         // level and its delayed copy, so a reset never produces a pulse.
         ctl_last_q  <= deb_q[2];
         ctl_pulse_q <= deb_q[2] & ~ctl_last_q;
      end
   end

   assign sw_row    = sw_row_q;
   assign sw_addr   = {deb_q[1], deb_q[0]};
   assign ctl_level = deb_q[2];
   assign ctl_pulse = ctl_pulse_q;
   assign frame     = frame_q;

endmodule

// File: tb/tb_panel_switch_scanner.sv
// Bench for panel_switch_scanner with SCAN_DIV=8, DEBOUNCE=3, driving the
// columns from a diode switch-matrix model. Cycle k counts clocks since the
// last reset edge; k=0 is the first cycle with div=0 and row0.
module tb_panel_switch_scanner;

   localparam int SCAN_DIV = 8;
   localparam int DEBOUNCE = 3;
   localparam int FRAME    = 3 * SCAN_DIV;
   localparam int HMAX     = 1024;
   localparam int NVEC     = 20;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  sw_col;
   logic [2:0]  sw_row;
   logic [15:0] sw_addr;
   logic [7:0]  ctl_level;
   logic [7:0]  ctl_pulse;
   logic        frame;

   always #5 clk = ~clk;

   panel_switch_scanner #(
      .SCAN_DIV (SCAN_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .sw_col    (sw_col),
      .sw_row    (sw_row),
      .sw_addr   (sw_addr),
      .ctl_level (ctl_level),
      .ctl_pulse (ctl_pulse),
      .frame     (frame)
   );

   // Switch matrix with diodes: a closed switch pulls its column low only
   // while its own row is driven low. sw_state: 1 = closed.
   logic [7:0] sw_state [3];

   always_comb begin
      sw_col = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         if (sw_row[i] == 1'b0) sw_col = sw_col & ~sw_state[i];
      end
   end

   // ---------------- scoreboard / reference model ----------------
   int         checks = 0;
   int         failures = 0;
   int         k = 0;
   logic [7:0] deb_m [3];          // expected debounced level per row
   logic [7:0] hist  [3][HMAX];    // every sample taken per row since reset
   int         nsamp [3];
   logic [7:0] exp_q [$];          // expected ctl_pulse for the next cycle
   int         pulse_cnt = 0;
   logic [7:0] pulse_or = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, k, act, exp);
      end
   endtask

   // Advance one clock and check every output against the model.
   // A row's debounced value follows the last sample once its last
   // DEBOUNCE samples since reset are all identical.
   task automatic step();
      int         pk;
      int         r;
      logic [7:0] rise, old, last, exp_pulse;
      logic [2:0] exp_row;
      logic       same;
      @(posedge clk);
      #1;
      pk = k;
      k  = k + 1;
      exp_pulse = exp_q.pop_front();
      rise = 8'h00;
      if (pk % SCAN_DIV == SCAN_DIV - 1) begin
         r    = (pk / SCAN_DIV) % 3;
         last = sw_state[r];
         if (nsamp[r] < HMAX) hist[r][nsamp[r]] = last;
         nsamp[r]++;
         if (nsamp[r] >= DEBOUNCE && nsamp[r] <= HMAX) begin
            same = 1'b1;
            for (int j = 1; j < DEBOUNCE; j++) begin
               if (hist[r][nsamp[r] - 1 - j] != last) same = 1'b0;
            end
            if (same) begin
               old      = deb_m[r];
               deb_m[r] = last;
               if (r == 2) rise = last & ~old;
            end
         end
      end
      exp_q.push_back(rise);
      exp_row = 3'b111;
      exp_row[(k / SCAN_DIV) % 3] = 1'b0;
      chk("sw_row", sw_row, exp_row);
      chk("frame", frame, (k % FRAME == 0) ? 1 : 0);
      chk("sw_addr", sw_addr, {deb_m[1], deb_m[0]});
      chk("ctl_level", ctl_level, deb_m[2]);
      chk("ctl_pulse", ctl_pulse, exp_pulse);
      if (ctl_pulse != 8'h00) pulse_cnt++;
      pulse_or = pulse_or | ctl_pulse;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      k = 0;
      for (int i = 0; i < 3; i++) begin
         deb_m[i] = 8'h00;
         nsamp[i] = 0;
      end
      exp_q.delete();
      exp_q.push_back(8'h00);
      chk("rst_sw_row", sw_row, 3'b110);
      chk("rst_sw_addr", sw_addr, 16'h0000);
      chk("rst_ctl_level", ctl_level, 8'h00);
      chk("rst_ctl_pulse", ctl_pulse, 8'h00);
      chk("rst_frame", frame, 1'b0);
   endtask

   task automatic run_frames(input int n);
      repeat (n * FRAME) step();
   endtask

   function automatic logic [7:0] pick_pattern();
      case ($urandom_range(0, 2))
         0:       return 8'h00;
         1:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic random_slots(input int n);
      for (int s = 0; s < n; s++) begin
         if ($urandom_range(0, 3) == 0) sw_state[$urandom_range(0, 2)] = pick_pattern();
         repeat (SCAN_DIV) step();
      end
   endtask

   // ---------------- frame-level vector table ----------------
   typedef struct packed {
      logic [7:0]  row0;
      logic [7:0]  row1;
      logic [7:0]  row2;
      logic [15:0] exp_addr;   // after the frame's samples
      logic [7:0]  exp_ctl;
      logic [7:0]  exp_pulse;  // OR of ctl_pulse seen during the frame
   } vec_t;

   vec_t vecs [NVEC];

   initial begin
      #1000000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", k);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;

      // A0/A15 closed, then DEPOSIT; A7 toggles every frame while A8 holds;
      // EXAMINE bounces closed,open,closed,closed,closed then releases;
      // finally everything opens.
      vecs[0]  = '{8'h01, 8'h80, 8'h00, 16'h0000, 8'h00, 8'h00};
      vecs[1]  = '{8'h01, 8'h80, 8'h00, 16'h0000, 8'h00, 8'h00};
      vecs[2]  = '{8'h01, 8'h80, 8'h00, 16'h8001, 8'h00, 8'h00};
      vecs[3]  = '{8'h01, 8'h80, 8'h20, 16'h8001, 8'h00, 8'h00};
      vecs[4]  = '{8'h01, 8'h80, 8'h20, 16'h8001, 8'h00, 8'h00};
      vecs[5]  = '{8'h01, 8'h80, 8'h20, 16'h8001, 8'h20, 8'h00};
      vecs[6]  = '{8'h81, 8'h81, 8'h20, 16'h8001, 8'h20, 8'h20};
      vecs[7]  = '{8'h01, 8'h81, 8'h20, 16'h8001, 8'h20, 8'h00};
      vecs[8]  = '{8'h81, 8'h81, 8'h20, 16'h8101, 8'h20, 8'h00};
      vecs[9]  = '{8'h01, 8'h81, 8'h28, 16'h8101, 8'h20, 8'h00};
      vecs[10] = '{8'h81, 8'h81, 8'h20, 16'h8101, 8'h20, 8'h00};
      vecs[11] = '{8'h01, 8'h81, 8'h28, 16'h8101, 8'h20, 8'h00};
      vecs[12] = '{8'h81, 8'h81, 8'h28, 16'h8101, 8'h20, 8'h00};
      vecs[13] = '{8'h01, 8'h81, 8'h28, 16'h8101, 8'h28, 8'h00};
      vecs[14] = '{8'h81, 8'h81, 8'h20, 16'h8101, 8'h28, 8'h08};
      vecs[15] = '{8'h01, 8'h81, 8'h20, 16'h8101, 8'h28, 8'h00};
      vecs[16] = '{8'h81, 8'h81, 8'h20, 16'h8101, 8'h20, 8'h00};
      vecs[17] = '{8'h00, 8'h00, 8'h00, 16'h8101, 8'h20, 8'h00};
      vecs[18] = '{8'h00, 8'h00, 8'h00, 16'h8101, 8'h20, 8'h00};
      vecs[19] = '{8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 8'h00};

      for (int i = 0; i < 3; i++) sw_state[i] = 8'h00;
      repeat (3) @(posedge clk);

      // Scan sequence with all switches open.
      do_reset();
      repeat (SCAN_DIV) step();
      chk("seq_row1", sw_row, 3'b101);
      repeat (SCAN_DIV) step();
      chk("seq_row2", sw_row, 3'b011);
      chk("seq_frame_low", frame, 1'b0);
      repeat (SCAN_DIV) step();
      chk("seq_row0", sw_row, 3'b110);
      chk("seq_frame_high", frame, 1'b1);
      step();
      chk("seq_frame_single", frame, 1'b0);

      // Frame-level table.
      do_reset();
      for (int f = 0; f < NVEC; f++) begin
         sw_state[0] = vecs[f].row0;
         sw_state[1] = vecs[f].row1;
         sw_state[2] = vecs[f].row2;
         pulse_or = 8'h00;
         run_frames(1);
         chk($sformatf("vec%0d_addr", f), sw_addr, vecs[f].exp_addr);
         chk($sformatf("vec%0d_ctl", f), ctl_level, vecs[f].exp_ctl);
         chk($sformatf("vec%0d_pulse", f), pulse_or, vecs[f].exp_pulse);
         chk($sformatf("vec%0d_frame", f), frame, 1'b1);
      end

      // RUN held, then a one-clock reset part way into a slot.
      do_reset();
      sw_state[0] = 8'h00;
      sw_state[1] = 8'h00;
      sw_state[2] = 8'h01;
      pulse_cnt = 0;
      run_frames(3);
      chk("run_level", ctl_level, 8'h01);
      chk("run_no_early_pulse", pulse_cnt, 0);
      n = $urandom_range(2, 20);
      pulse_cnt = 0;
      repeat (n) step();
      chk("run_pulse_once", pulse_cnt, 1);
      do_reset();
      pulse_cnt = 0;
      run_frames(2);
      chk("rerun_level_wait", ctl_level, 8'h00);
      chk("rerun_no_pulse", pulse_cnt, 0);
      run_frames(1);
      chk("rerun_level", ctl_level, 8'h01);
      chk("rerun_no_pulse_yet", pulse_cnt, 0);
      run_frames(10);
      chk("rerun_single_pulse", pulse_cnt, 1);

      // Randomized patterns checked cycle by cycle, with a mid-slot reset.
      do_reset();
      random_slots(180);
      repeat ($urandom_range(1, SCAN_DIV - 1)) step();
      do_reset();
      random_slots(180);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
